// File: rtl/cmp_pkg.sv
// Shared types and result encodings for the comparator result filter.
// Results are packed {g,l,e}, so a legal sample is exactly one of RES_G/RES_L/RES_E.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_G    = 3'b100;
  localparam logic [2:0] RES_L    = 3'b010;
  localparam logic [2:0] RES_E    = 3'b001;

  function automatic logic is_legal(input logic [2:0] res);
    return (res == RES_G) || (res == RES_L) || (res == RES_E);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/cmp_result_filter.sv
// Debounces raw comparator g/l/e flags into a locked one-hot result.
// Optional per-outcome statistics are built only when CMP_STATS_EN is defined.
module cmp_result_filter
  import cmp_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          g,
  input  logic          l,
  input  logic          e,
  output logic          stable_g,
  output logic          stable_l,
  output logic          stable_e,
  output logic          out_valid,
  output logic          err,
  output logic [CW-1:0] cnt_g,
  output logic [CW-1:0] cnt_l,
  output logic [CW-1:0] cnt_e
);

  localparam logic [4:0] LOCK_AT = 5'(STABLE_CNT);
  localparam logic [3:0] RUN_SAT = 4'(STABLE_CNT);

  state_t     state_reg;
  logic [2:0] cand_reg;
  logic [2:0] stable_reg;
  logic [3:0] run_reg;
  logic       out_valid_reg;
  logic       err_reg;

  logic [2:0] sample;
  logic       legal;
  logic       accept;
  logic       start_run;
  logic       extend_run;
  logic       do_lock;
  logic [4:0] run_inc;

  assign sample = {g, l, e};
  assign legal  = is_legal(sample);
  assign accept = in_valid & legal;

  // A sample either restarts the run at 1, extends the current run, or is ignored
  // (LOCK and matching the stable value). Either of the first two may complete a lock.
  always_comb begin
    start_run  = 1'b0;
    extend_run = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE:    start_run = 1'b1;
        CAND: begin
          if (sample == cand_reg) extend_run = 1'b1;
          else                    start_run  = 1'b1;
        end
        LOCK:    start_run = (sample != stable_reg);
        default: start_run = 1'b1;
      endcase
    end
    run_inc = start_run ? 5'd1 : ({1'b0, run_reg} + 5'd1);
    do_lock = (start_run | extend_run) && (run_inc >= LOCK_AT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cand_reg      <= RES_NONE;
      stable_reg    <= RES_NONE;
      run_reg       <= 4'd0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      if (in_valid && !legal) begin
        err_reg   <= 1'b1;
        cand_reg  <= RES_NONE;
        run_reg   <= 4'd0;
        state_reg <= IDLE;
      end else if (start_run || extend_run) begin
        cand_reg <= sample;
        if (do_lock) begin
          state_reg <= LOCK;
          run_reg   <= RUN_SAT;
          // Re-locking on the value already published is silent.
          if (sample != stable_reg) begin
            stable_reg    <= sample;
            out_valid_reg <= 1'b1;
          end
        end else begin
          state_reg <= CAND;
          run_reg   <= run_inc[3:0];
        end
      end
    end
  end

  assign stable_g  = stable_reg[2];
  assign stable_l  = stable_reg[1];
  assign stable_e  = stable_reg[0];
  assign out_valid = out_valid_reg;
  assign err       = err_reg;

`ifdef CMP_STATS_EN
  logic [CW-1:0] cnt_arr [3];

  // Index follows the {g,l,e} packing: 2=g, 1=l, 0=e.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      sat_counter #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept & sample[gi]),
        .cnt   (cnt_arr[gi])
      );
    end
  endgenerate

  assign cnt_g = cnt_arr[2];
  assign cnt_l = cnt_arr[1];
  assign cnt_e = cnt_arr[0];
`else
  assign cnt_g = '0;
  assign cnt_l = '0;
  assign cnt_e = '0;
`endif

endmodule
